cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Parametrised run-control and instruction-trace block for the single-cycle CPU core.
//  - Sequences the core reset after power-up or on request.
//  - Captures {pc, inst} pairs into a circular or stop-when-full buffer.
//  - Freezes capture a programmable number of entries after a pc breakpoint.
//  - Drains captured entries oldest-first through a read port; sits beside cpu_mem_final.
// PARAMETERS
//  AW        32  pc width
//  DW        32  instruction width
//  DEPTH     16  trace entries; power of 2, >=2
//  RST_CYC   4   cycles cpu_rst held high per reset sequence; >=1
//  POST_TRIG 4   entries captured after the breakpoint entry before freezing; 0..DEPTH-1
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  rst_req    in   1                  1-cycle pulse: restart reset sequence and clear trace
//  cpu_rst    out  1                  active-high reset to the CPU core
//  pc         in   AW                 core program counter
//  inst       in   DW                 core current instruction
//  mode       in   1                  0 = circular (overwrite oldest), 1 = stop when full
//  trig_en    in   1                  breakpoint enable
//  trig_pc    in   AW                 breakpoint address
//  rd_en      in   1                  pop one entry; honoured only in FROZEN with count>0
//  rd_data    out  AW+DW              {pc,inst} of popped entry
//  rd_valid   out  1                  1-cycle strobe, rd_data valid
//  count      out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  frozen     out  1                  capture stopped
//  cycle_cnt  out  32                 cycles since cpu_rst fell; wraps at 2^32
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=RST_SEQ, cpu_rst=1, rd_data=0, rd_valid=0,
//    count=0, frozen=0, cycle_cnt=0, write/read pointers=0, last_pc=all-ones.
//  RST_SEQ: cpu_rst=1 for RST_CYC cycles after rst_n rises, then cpu_rst=0 and go to RUN.
//    No capture. cycle_cnt stays at 0.
//  RUN: cycle_cnt increments every cycle.
//    - Capture condition: pc != last_pc.
//    - On capture, write {pc,inst} at wr_ptr, advance wr_ptr mod DEPTH, set last_pc=pc.
//    - The first cycle after reset always captures, because last_pc starts at all-ones.
//  Full, mode=0: wr_ptr and rd_ptr both advance and count stays at DEPTH.
//  Full, mode=1: the capture is dropped and state goes to FROZEN.
//  Breakpoint:
//    - Hits when trig_en=1, a capture occurs, and pc==trig_pc.
//    - Arms a post-counter at POST_TRIG.
//    - Each later capture decrements it.
//    - State goes to FROZEN when the counter is 0 after a capture.
//    - POST_TRIG=0 freezes on the breakpoint entry itself.
//    - Only the first hit arms; later hits are ignored until cleared.
//  FROZEN: frozen=1, no capture, cycle_cnt holds. The core is not stopped; cpu_rst stays 0.
//  Read:
//    - rd_en in FROZEN with count>0: rd_data=entry at rd_ptr, rd_valid=1 on the next edge.
//    - rd_ptr advances and count decrements.
//    - rd_en with count=0, or outside FROZEN: ignored, rd_valid=0.
//  rst_req (any state): the next edge enters RST_SEQ.
//    - Clears pointers, count, frozen, the post-counter and last_pc (to all-ones).
//    - Zeroes cycle_cnt.
//    - Deasserts rd_valid; a read in the same cycle is discarded.
//  Simultaneous capture and full in mode=0: overwrite wins; the breakpoint still evaluates.
//  Breakpoint and full in mode=1 on the same cycle: the entry is dropped, FROZEN, count=DEPTH.
//  Pointer arithmetic: $clog2(DEPTH) bits, natural wrap.
//  count is a separate counter so that full (DEPTH) and empty (0) are unambiguous.
// TESTING
//  T1 Reset sequence: rst_n low 2 cycles, release.
//     -> cpu_rst=1 exactly 4 cycles, then 0. cycle_cnt counts 0,1,2...; count=0.
//  T2 Capture filter: pc sequence 0,4,4,8.
//     -> count=3; drained entries {0},{4},{8} with matching inst.
//  T3 Circular wrap, DEPTH=16, mode=0: pcs 0..76 step 4 (20 entries), trig_pc=76, POST_TRIG=0.
//     -> frozen on pc=76, count=16, first read pc=16, last read pc=76.
//  T4 Stop-full, mode=1: 20 distinct pcs.
//     -> frozen after the 16th capture (pc=60), count=16, reads 0..60; the 17th is not stored.
//  T5 Breakpoint and post-trigger, trig_pc=0x20, POST_TRIG=4.
//     -> freezes after pc=0x30 is captured; the last entry read is 0x30.
//     -> rd_en at count=0 gives rd_valid=0.
//  T6 rst_req mid-drain (count=5) with rd_en high in the same cycle.
//     -> no rd_valid; count=0, frozen=0, cpu_rst high 4 cycles, capture resumes.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Run-control and instruction-trace buffer for the single-cycle CPU core.
// Sequences core reset, captures {pc,inst} on pc change, freezes on full/breakpoint, drains oldest-first.
module cpu_trace_buffer #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned RST_CYC   = 4,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rst_req,
  output logic                     cpu_rst,
  input  logic [AW-1:0]            pc,
  input  logic [DW-1:0]            inst,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [AW-1:0]            trig_pc,
  input  logic                     rd_en,
  output logic [AW+DW-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frozen,
  output logic [31:0]              cycle_cnt
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned EW  = AW + DW;
  localparam int unsigned RCW = $clog2(RST_CYC + 1);
  localparam int unsigned TW  = PW + 1;

  typedef enum logic [1:0] {
    ST_RST_SEQ = 2'd0,
    ST_RUN     = 2'd1,
    ST_FROZEN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nxt_state;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_last_pc;
  logic [RCW-1:0]   r_rst_cnt;
  logic [TW-1:0]    r_post;
  logic             r_armed;
  logic             r_cpu_rst;
  logic             r_frozen;
  logic [EW-1:0]    r_rd_data;
  logic             r_rd_valid;
  logic [31:0]      r_cycle_cnt;

  logic             w_cap;
  logic             w_full;
  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic             w_arm;
  logic             w_dec;

  assign w_cap  = (pc != r_last_pc);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_hit  = trig_en && (pc == trig_pc) && !r_armed;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RST_SEQ;
    else        r_state <= w_nxt_state;
  end

  // Next state and per-cycle capture/read decisions
  always_comb begin
    w_nxt_state = r_state;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_arm       = 1'b0;
    w_dec       = 1'b0;
    if (rst_req) begin
      w_nxt_state = ST_RST_SEQ;
    end else begin
      case (r_state)
        ST_RST_SEQ: begin
          if (r_rst_cnt == RCW'(RST_CYC - 1)) w_nxt_state = ST_RUN;
        end
        ST_RUN: begin
          if (w_cap) begin
            // stop-when-full drops the entry and freezes; breakpoint is not evaluated
            if (w_full && mode) begin
              w_nxt_state = ST_FROZEN;
            end else begin
              w_wr = 1'b1;
              if (w_hit) begin
                w_arm = 1'b1;
                if (POST_TRIG == 0) w_nxt_state = ST_FROZEN;
              end else if (r_armed) begin
                w_dec = 1'b1;
                if (r_post == TW'(1)) w_nxt_state = ST_FROZEN;
              end
            end
          end
        end
        ST_FROZEN: begin
          w_rd = rd_en && (r_count != '0);
        end
        default: w_nxt_state = ST_RST_SEQ;
      endcase
    end
  end

  // Trace storage (no reset needed; count qualifies validity)
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {pc, inst};
  end

  // Pointers, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last_pc   <= '1;
      r_rst_cnt   <= '0;
      r_post      <= '0;
      r_armed     <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_frozen    <= 1'b0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_cpu_rst <= (w_nxt_state == ST_RST_SEQ);
      r_frozen  <= (w_nxt_state == ST_FROZEN);
      if (rst_req) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_last_pc   <= '1;
        r_rst_cnt   <= '0;
        r_post      <= '0;
        r_armed     <= 1'b0;
        r_rd_valid  <= 1'b0;
        r_cycle_cnt <= '0;
      end else begin
        r_rst_cnt  <= (r_state == ST_RST_SEQ) ? r_rst_cnt + RCW'(1) : '0;
        r_rd_valid <= w_rd;
        if (r_state == ST_RUN) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        if (w_wr) begin
          r_wr_ptr  <= r_wr_ptr + PW'(1);
          r_last_pc <= pc;
          // circular overwrite: oldest entry is discarded, count stays at DEPTH
          if (w_full) r_rd_ptr <= r_rd_ptr + PW'(1);
          else        r_count  <= r_count + CW'(1);
        end
        if (w_arm)      r_post <= TW'(POST_TRIG);
        else if (w_dec) r_post <= r_post - TW'(1);
        if (w_arm) r_armed <= 1'b1;
        if (w_rd) begin
          r_rd_data <= r_mem[r_rd_ptr];
          r_rd_ptr  <= r_rd_ptr + PW'(1);
          r_count   <= r_count - CW'(1);
        end
      end
    end
  end

  assign cpu_rst   = r_cpu_rst;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign count     = r_count;
  assign frozen    = r_frozen;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: two instances (POST_TRIG=0 and POST_TRIG=4) share stimulus.
module tb_cpu_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic        rst_req;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        mode;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_en;

  logic        cpu_rst0, rd_valid0, frozen0;
  logic [63:0] rd_data0;
  logic [4:0]  count0;
  logic [31:0] cycle_cnt0;
  logic        cpu_rst4, rd_valid4, frozen4;
  logic [63:0] rd_data4;
  logic [4:0]  count4;
  logic [31:0] cycle_cnt4;

  int vectors;
  int miscompares;

  cpu_trace_buffer #(.AW(32), .DW(32), .DEPTH(16), .RST_CYC(4), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .cpu_rst(cpu_rst0), .pc(pc), .inst(inst),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .count(count0), .frozen(frozen0), .cycle_cnt(cycle_cnt0)
  );

  cpu_trace_buffer #(.AW(32), .DW(32), .DEPTH(16), .RST_CYC(4), .POST_TRIG(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rst_req(rst_req), .cpu_rst(cpu_rst4), .pc(pc), .inst(inst),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .rd_en(rd_en), .rd_data(rd_data4),
    .rd_valid(rd_valid4), .count(count4), .frozen(frozen4), .cycle_cnt(cycle_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'hA5A5_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [31:0] p);
    pc   = p;
    inst = inst_of(p);
    tick();
  endtask

  task automatic restart();
    rd_en   = 1'b0;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    for (int i = 0; i < 20 && (cpu_rst0 || cpu_rst4); i++) tick();
    vectors++;
    if (cpu_rst0 !== 1'b0 || cpu_rst4 !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_timeout: cpu_rst0=%b cpu_rst4=%b required 0", cpu_rst0, cpu_rst4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_req = 1'b0; rd_en = 1'b0; mode = 1'b0;
    trig_en = 1'b0; trig_pc = 32'h0; pc = 32'h0; inst = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (cpu_rst0 !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_rst: got %b required 1", cpu_rst0); end
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d required 0", count0); end
    vectors++; if (frozen0 !== 1'b0) begin miscompares++; $display("FAIL rst_frozen: got %b required 0", frozen0); end
    vectors++; if (cycle_cnt0 !== 32'd0) begin miscompares++; $display("FAIL rst_cycle_cnt: got %0d required 0", cycle_cnt0); end
    vectors++; if (rd_valid0 !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b required 0", rd_valid0); end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (cpu_rst0 !== (i < 4)) begin miscompares++; $display("FAIL rst_seq_cpu_rst cycle %0d: got %b required %b", i, cpu_rst0, (i < 4)); end
    end
    vectors++; if (cycle_cnt0 !== 32'd0) begin miscompares++; $display("FAIL rst_seq_cycle0: got %0d required 0", cycle_cnt0); end
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL rst_seq_count: got %0d required 0", count0); end
    for (int i = 1; i <= 2; i++) begin
      tick();
      vectors++;
      if (cycle_cnt0 !== 32'(i)) begin miscompares++; $display("FAIL run_cycle_cnt: got %0d required %0d", cycle_cnt0, i); end
    end
  endtask

  task automatic test_capture_filter();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h8;
    restart();
    cap(32'h0);
    cap(32'h4);
    pc = 32'h4; inst = 32'h1234_5678; tick();
    vectors++; if (count0 !== 5'd2) begin miscompares++; $display("FAIL filter_repeat_count: got %0d required 2", count0); end
    cap(32'h8);
    vectors++; if (count0 !== 5'd3) begin miscompares++; $display("FAIL filter_count: got %0d required 3", count0); end
    vectors++; if (frozen0 !== 1'b1) begin miscompares++; $display("FAIL filter_frozen: got %b required 1", frozen0); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== {exp_pc[i], inst_of(exp_pc[i])}) begin
        miscompares++;
        $display("FAIL filter_read %0d: valid=%b data=%h required valid=1 data=%h", i, rd_valid0, rd_data0, {exp_pc[i], inst_of(exp_pc[i])});
      end
    end
    rd_en = 1'b0;
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL filter_drained: got %0d required 0", count0); end
  endtask

  task automatic test_circular_wrap();
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'd76;
    restart();
    for (int i = 0; i < 20; i++) begin
      cap(32'(4 * i));
      if (i == 18) begin
        vectors++;
        if (frozen0 !== 1'b0 || count0 !== 5'd16) begin miscompares++; $display("FAIL wrap_full_running: frozen=%b count=%0d required frozen=0 count=16", frozen0, count0); end
      end
    end
    vectors++; if (frozen0 !== 1'b1) begin miscompares++; $display("FAIL wrap_frozen: got %b required 1", frozen0); end
    vectors++; if (count0 !== 5'd16) begin miscompares++; $display("FAIL wrap_count: got %0d required 16", count0); end
    vectors++; if (cycle_cnt0 !== 32'd20) begin miscompares++; $display("FAIL wrap_cycle_cnt: got %0d required 20", cycle_cnt0); end
    cap(32'd80);
    vectors++; if (count0 !== 5'd16) begin miscompares++; $display("FAIL wrap_no_capture_frozen: got %0d required 16", count0); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== {32'(16 + 4 * i), inst_of(32'(16 + 4 * i))}) begin
        miscompares++;
        $display("FAIL wrap_read %0d: valid=%b data=%h required pc=%0d", i, rd_valid0, rd_data0, 16 + 4 * i);
      end
    end
    rd_en = 1'b0;
    vectors++; if (cycle_cnt0 !== 32'd20) begin miscompares++; $display("FAIL wrap_cycle_hold: got %0d required 20", cycle_cnt0); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    vectors++; if (rd_valid0 !== 1'b0) begin miscompares++; $display("FAIL wrap_read_empty: got %b required 0", rd_valid0); end
  endtask

  task automatic test_stop_full();
    mode = 1'b1; trig_en = 1'b0; trig_pc = 32'h0;
    restart();
    for (int i = 0; i < 17; i++) begin
      cap(32'(4 * i));
      if (i == 15) begin
        vectors++;
        if (count0 !== 5'd16 || frozen0 !== 1'b0) begin miscompares++; $display("FAIL full_at_16: count=%0d frozen=%b required count=16 frozen=0", count0, frozen0); end
      end
    end
    vectors++; if (frozen0 !== 1'b1) begin miscompares++; $display("FAIL full_frozen: got %b required 1", frozen0); end
    vectors++; if (count0 !== 5'd16) begin miscompares++; $display("FAIL full_count: got %0d required 16", count0); end
    vectors++; if (cycle_cnt0 !== 32'd17) begin miscompares++; $display("FAIL full_cycle_cnt: got %0d required 17", cycle_cnt0); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (rd_valid0 !== 1'b1 || rd_data0 !== {32'(4 * i), inst_of(32'(4 * i))}) begin
        miscompares++;
        $display("FAIL full_read %0d: valid=%b data=%h required pc=%0d", i, rd_valid0, rd_data0, 4 * i);
      end
    end
    rd_en = 1'b0;
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL full_drained: got %0d required 0", count0); end
  endtask

  task automatic test_post_trigger();
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h20;
    restart();
    for (int i = 0; i < 14; i++) begin
      cap(32'(4 * i));
      if (i == 11) begin
        vectors++;
        if (frozen4 !== 1'b0) begin miscompares++; $display("FAIL post_early_freeze: got %b required 0", frozen4); end
      end
      if (i == 12) begin
        vectors++;
        if (frozen4 !== 1'b1) begin miscompares++; $display("FAIL post_freeze_at_0x30: got %b required 1", frozen4); end
      end
    end
    vectors++; if (count4 !== 5'd13) begin miscompares++; $display("FAIL post_count: got %0d required 13", count4); end
    rd_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      vectors++;
      if (rd_valid4 !== 1'b1 || rd_data4 !== {32'(4 * i), inst_of(32'(4 * i))}) begin
        miscompares++;
        $display("FAIL post_read %0d: valid=%b data=%h required pc=%0h", i, rd_valid4, rd_data4, 4 * i);
      end
    end
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_valid4 !== 1'b0) begin miscompares++; $display("FAIL post_read_empty: got %b required 0", rd_valid4); end
    vectors++; if (count4 !== 5'd0) begin miscompares++; $display("FAIL post_count_empty: got %0d required 0", count4); end
  endtask

  task automatic test_rst_req_mid_drain();
    mode = 1'b0; trig_en = 1'b1; trig_pc = 32'h100;
    restart();
    for (int i = 0; i < 6; i++) cap(32'h0EC + 32'(4 * i));
    vectors++; if (count0 !== 5'd6 || frozen0 !== 1'b1) begin miscompares++; $display("FAIL drain_setup: count=%0d frozen=%b required count=6 frozen=1", count0, frozen0); end
    rd_en = 1'b1; tick();
    vectors++; if (rd_valid0 !== 1'b1 || count0 !== 5'd5) begin miscompares++; $display("FAIL drain_first: valid=%b count=%0d required valid=1 count=5", rd_valid0, count0); end
    rst_req = 1'b1; tick();
    rst_req = 1'b0; rd_en = 1'b0; trig_en = 1'b0;
    vectors++; if (rd_valid0 !== 1'b0) begin miscompares++; $display("FAIL rstreq_rd_valid: got %b required 0", rd_valid0); end
    vectors++; if (count0 !== 5'd0) begin miscompares++; $display("FAIL rstreq_count: got %0d required 0", count0); end
    vectors++; if (frozen0 !== 1'b0) begin miscompares++; $display("FAIL rstreq_frozen: got %b required 0", frozen0); end
    vectors++; if (cycle_cnt0 !== 32'd0) begin miscompares++; $display("FAIL rstreq_cycle_cnt: got %0d required 0", cycle_cnt0); end
    vectors++; if (cpu_rst0 !== 1'b1) begin miscompares++; $display("FAIL rstreq_cpu_rst: got %b required 1", cpu_rst0); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (cpu_rst0 !== (i < 4)) begin miscompares++; $display("FAIL rstreq_seq cycle %0d: got %b required %b", i, cpu_rst0, (i < 4)); end
    end
    cap(32'h200);
    vectors++; if (count0 !== 5'd1 || frozen0 !== 1'b0) begin miscompares++; $display("FAIL rstreq_resume: count=%0d frozen=%b required count=1 frozen=0", count0, frozen0); end
    vectors++; if (cycle_cnt0 !== 32'd1) begin miscompares++; $display("FAIL rstreq_resume_cycle: got %0d required 1", cycle_cnt0); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    rst_req = 1'b0;
    rd_en   = 1'b0;
    mode    = 1'b0;
    trig_en = 1'b0;
    trig_pc = 32'h0;
    pc      = 32'h0;
    inst    = 32'h0;
    test_reset();
    test_capture_filter();
    test_circular_wrap();
    test_stop_full();
    test_post_trigger();
    test_rst_req_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
